// File: rtl/data_array_pkg.sv
// Shared defaults and FSM encodings for the L1 cache data array.
package data_array_pkg;

    localparam int CACHE_BANK_NUM  = 4;
    localparam int CACHE_INDEX_AW  = 8;
    localparam int CACHE_OFFSET_AW = 4;
    localparam int DATA_WIDTH      = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/data_array_bank.sv
// Single data bank: byte-masked synchronous write, registered read.
// Build option DATA_ARRAY_BYPASS_EN: a read and a write to the same
// address in the same cycle return the word with the written bytes merged.
module data_bank #(
    parameter int DW = 32,
    parameter int AW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            re,
    input  logic [AW-1:0]   raddr,
    input  logic [DW/8-1:0] we,
    input  logic [AW-1:0]   waddr,
    input  logic [DW-1:0]   wdata,
    output logic [DW-1:0]   rdata
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rd_word;

    // Word presented to the read register, optionally with same-cycle store merged in
    always_comb begin
        rd_word = mem[raddr];
`ifdef DATA_ARRAY_BYPASS_EN
        if (waddr == raddr) begin
            for (int b = 0; b < DW/8; b++) begin
                if (we[b]) rd_word[b*8 +: 8] = wdata[b*8 +: 8];
            end
        end
`endif
    end

    // Storage is deliberately not reset
    always_ff @(posedge clk) begin
        for (int b = 0; b < DW/8; b++) begin
            if (we[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
    end

    // Read register holds its value until the next enabled read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= rd_word;
    end

endmodule

// File: rtl/data_array.sv
// Cache-line data array: whole-line reads, byte-masked bank stores and a
// beat-per-bank refill engine. Build option DATA_ARRAY_BYPASS_EN merges a
// same-cycle, same-index store into the read result.
module data_array
    import data_array_pkg::*;
#(
    parameter int BANK_NUM  = CACHE_BANK_NUM,
    parameter int BANK_DW   = DATA_WIDTH,
    parameter int INDEX_AW  = CACHE_INDEX_AW,
    parameter int OFFSET_AW = $clog2(BANK_NUM*BANK_DW/8)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rd_req_i,
    input  logic [INDEX_AW-1:0]         rd_index_i,
    output logic                        rd_gnt_o,
    output logic                        rd_valid_o,
    output logic [BANK_NUM*BANK_DW-1:0] rd_data_o,
    input  logic [BANK_DW/8-1:0]        st_wen_i,
    input  logic [INDEX_AW-1:0]         st_index_i,
    input  logic [OFFSET_AW-1:0]        st_offset_i,
    input  logic [BANK_DW-1:0]          st_data_i,
    output logic                        st_gnt_o,
    input  logic                        refill_start_i,
    input  logic [INDEX_AW-1:0]         refill_index_i,
    input  logic                        refill_valid_i,
    input  logic [BANK_DW-1:0]          refill_data_i,
    output logic                        refill_ready_o,
    output logic                        refill_done_o,
    output logic                        busy_o
);

    localparam int CNT_W   = $clog2(BANK_NUM);
    localparam int BYTE_AW = $clog2(BANK_DW/8);

    state_t                             state, state_nxt;
    logic [CNT_W-1:0]                   cnt;
    logic [INDEX_AW-1:0]                ref_index;
    logic                               idle, refill_beat, last_beat;
    logic [CNT_W-1:0]                   bank_sel;
    logic [INDEX_AW-1:0]                waddr;
    logic [BANK_DW-1:0]                 wdata;
    logic [BANK_NUM-1:0][BANK_DW/8-1:0] bank_we;
    logic                               unused_offset;

    assign idle           = (state == IDLE);
    assign refill_beat    = (state == REFILL) && refill_valid_i;
    assign last_beat      = refill_beat && (cnt == CNT_W'(BANK_NUM-1));
    assign rd_gnt_o       = rd_req_i & idle;
    assign st_gnt_o       = (|st_wen_i) & idle;
    assign refill_ready_o = (state == REFILL);
    assign refill_done_o  = (state == DONE);
    assign busy_o         = !idle;

    // Byte offset inside a bank is ignored; caller keeps stores aligned
    assign bank_sel      = st_offset_i[OFFSET_AW-1:BYTE_AW];
    assign unused_offset = ^st_offset_i[BYTE_AW-1:0];

    // Refill and CPU stores never overlap, so one shared write port suffices
    assign waddr = (state == REFILL) ? ref_index : st_index_i;
    assign wdata = (state == REFILL) ? refill_data_i : st_data_i;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (refill_start_i) state_nxt = REFILL;
            REFILL:  if (last_beat)      state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Refill index latch and beat counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            ref_index <= '0;
        end else if (idle && refill_start_i) begin
            cnt       <= '0;
            ref_index <= refill_index_i;
        end else if (refill_beat) begin
            cnt       <= cnt + 1'b1;
        end
    end

    // Per-bank byte enables: refill beat writes a whole bank, store writes one bank
    always_comb begin
        bank_we = '0;
        for (int i = 0; i < BANK_NUM; i++) begin
            if (refill_beat && (int'(cnt) == i))
                bank_we[i] = '1;
            else if (st_gnt_o && (int'(bank_sel) == i))
                bank_we[i] = st_wen_i;
        end
    end

    // Read valid follows the grant by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_valid_o <= 1'b0;
        else        rd_valid_o <= rd_gnt_o;
    end

    for (genvar i = 0; i < BANK_NUM; i++) begin : g_bank
        data_bank #(.DW(BANK_DW), .AW(INDEX_AW)) u_bank (
            .clk   (clk),
            .rst_n (rst_n),
            .re    (rd_gnt_o),
            .raddr (rd_index_i),
            .we    (bank_we[i]),
            .waddr (waddr),
            .wdata (wdata),
            .rdata (rd_data_o[i*BANK_DW +: BANK_DW])
        );
    end

endmodule

// File: tb/tb_data_array.sv
// Directed bench for data_array: table-driven store/read vectors plus
// hand-written refill, blocking, reset-abort and same-cycle hazard sequences.
module tb_data_array;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rd_req_i = 1'b0;
    logic [7:0]   rd_index_i = '0;
    logic         rd_gnt_o, rd_valid_o;
    logic [127:0] rd_data_o;
    logic [3:0]   st_wen_i = '0;
    logic [7:0]   st_index_i = '0;
    logic [3:0]   st_offset_i = '0;
    logic [31:0]  st_data_i = '0;
    logic         st_gnt_o;
    logic         refill_start_i = 1'b0;
    logic [7:0]   refill_index_i = '0;
    logic         refill_valid_i = 1'b0;
    logic [31:0]  refill_data_i = '0;
    logic         refill_ready_o, refill_done_o, busy_o;

    int n_chk = 0;
    int n_err = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    data_array dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req_i(rd_req_i), .rd_index_i(rd_index_i), .rd_gnt_o(rd_gnt_o),
        .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
        .st_wen_i(st_wen_i), .st_index_i(st_index_i), .st_offset_i(st_offset_i),
        .st_data_i(st_data_i), .st_gnt_o(st_gnt_o),
        .refill_start_i(refill_start_i), .refill_index_i(refill_index_i),
        .refill_valid_i(refill_valid_i), .refill_data_i(refill_data_i),
        .refill_ready_o(refill_ready_o), .refill_done_o(refill_done_o), .busy_o(busy_o)
    );

    always @(negedge clk) if (refill_done_o) done_cnt++;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        bit         is_rd;
        logic [7:0] idx;
        logic [3:0] off;
        logic [3:0] wen;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[9];

    task automatic do_store(input logic [7:0] idx, input logic [3:0] off,
                            input logic [3:0] wen, input logic [31:0] data);
        @(negedge clk);
        st_index_i = idx; st_offset_i = off; st_wen_i = wen; st_data_i = data;
        #1 chk("st_gnt", 128'(st_gnt_o), 128'(|wen));
        @(negedge clk);
        st_wen_i = '0;
    endtask

    task automatic do_read(input logic [7:0] idx, output logic [127:0] line);
        @(negedge clk);
        rd_req_i = 1'b1; rd_index_i = idx;
        #1 chk("rd_gnt", 128'(rd_gnt_o), 128'(1));
        @(negedge clk);
        rd_req_i = 1'b0;
        chk("rd_valid_n1", 128'(rd_valid_o), 128'(1));
        line = rd_data_o;
        @(negedge clk);
        chk("rd_valid_n2", 128'(rd_valid_o), 128'(0));
    endtask

    // Start a refill and push four beats without stalls
    task automatic do_refill(input logic [7:0] idx, input logic [31:0] base);
        @(negedge clk);
        refill_start_i = 1'b1; refill_index_i = idx;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            refill_start_i = 1'b0;
            refill_valid_i = 1'b1; refill_data_i = base + 32'(b);
        end
        @(negedge clk);
        refill_valid_i = 1'b0;
        chk("clean_done", 128'(refill_done_o), 128'(1));
        @(negedge clk);
    endtask

    initial begin
        logic [127:0] line;
        logic [127:0] exp_line;
        int           d0;

        vt[0] = '{0, 8'd5, 4'h8, 4'b1111, 32'hDEADBEEF, 32'h0};
        vt[1] = '{1, 8'd5, 4'h8, 4'b0000, 32'h0,        32'hDEADBEEF};
        vt[2] = '{0, 8'd5, 4'h8, 4'b0010, 32'h0000AB00, 32'h0};
        vt[3] = '{1, 8'd5, 4'h8, 4'b0000, 32'h0,        32'hDEADABEF};
        vt[4] = '{0, 8'd5, 4'hB, 4'b0001, 32'h00000012, 32'h0};
        vt[5] = '{1, 8'd5, 4'h8, 4'b0000, 32'h0,        32'hDEADAB12};
        vt[6] = '{0, 8'd5, 4'h8, 4'b0000, 32'hFFFFFFFF, 32'h0};
        vt[7] = '{0, 8'd6, 4'hC, 4'b1111, 32'hCAFEF00D, 32'h0};
        vt[8] = '{1, 8'd6, 4'hC, 4'b0000, 32'h0,        32'hCAFEF00D};

        // Reset state
        #12;
        chk("rst_rd_valid", 128'(rd_valid_o), 128'(0));
        chk("rst_rd_data", rd_data_o, 128'(0));
        chk("rst_ready", 128'(refill_ready_o), 128'(0));
        chk("rst_done", 128'(refill_done_o), 128'(0));
        chk("rst_busy", 128'(busy_o), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 9; v++) begin
            if (vt[v].is_rd) begin
                do_read(vt[v].idx, line);
                chk($sformatf("vec%0d_bank", v), 128'(line[vt[v].off[3:2]*32 +: 32]), 128'(vt[v].exp));
            end else begin
                do_store(vt[v].idx, vt[v].off, vt[v].wen, vt[v].data);
            end
        end

        // Refill index 3 with a 2-cycle stall, CPU traffic and a second start blocked
        do_store(8'd3, 4'h0, 4'b1111, 32'h0BADF00D);
        d0 = done_cnt;
        @(negedge clk);
        refill_start_i = 1'b1; refill_index_i = 8'd3;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            refill_start_i = 1'b0;
            refill_valid_i = 1'b0;
            if (b == 2) begin
                for (int s = 0; s < 2; s++) begin
                    rd_req_i = 1'b1; rd_index_i = 8'd3;
                    st_wen_i = 4'hF; st_index_i = 8'd3; st_offset_i = 4'h0; st_data_i = 32'h99999999;
                    refill_start_i = 1'b1; refill_index_i = 8'd9;
                    #1;
                    chk("blk_rd_gnt", 128'(rd_gnt_o), 128'(0));
                    chk("blk_st_gnt", 128'(st_gnt_o), 128'(0));
                    chk("blk_ready", 128'(refill_ready_o), 128'(1));
                    @(negedge clk);
                    rd_req_i = 1'b0; st_wen_i = '0; refill_start_i = 1'b0;
                    chk("blk_rd_valid", 128'(rd_valid_o), 128'(0));
                end
            end
            refill_valid_i = 1'b1; refill_data_i = 32'h11111111 * 32'(b + 1);
            #1 chk("refill_ready", 128'(refill_ready_o), 128'(1));
        end
        @(negedge clk);
        refill_valid_i = 1'b0;
        rd_req_i = 1'b1; rd_index_i = 8'd3;
        #1;
        chk("done_pulse", 128'(refill_done_o), 128'(1));
        chk("done_ready", 128'(refill_ready_o), 128'(0));
        chk("done_rd_gnt", 128'(rd_gnt_o), 128'(0));
        rd_req_i = 1'b0;
        @(negedge clk);
        chk("post_done", 128'(refill_done_o), 128'(0));
        chk("post_busy", 128'(busy_o), 128'(0));
        chk("done_count", 128'(done_cnt - d0), 128'(1));
        do_read(8'd3, line);
        chk("refill_line", line, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});

        // Reset after two beats aborts the refill without a done pulse
        d0 = done_cnt;
        @(negedge clk);
        refill_start_i = 1'b1; refill_index_i = 8'd10;
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            refill_start_i = 1'b0;
            refill_valid_i = 1'b1; refill_data_i = 32'hA0A0A0A0 + 32'(b);
        end
        @(negedge clk);
        refill_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 128'(busy_o), 128'(0));
        chk("abort_ready", 128'(refill_ready_o), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_no_done", 128'(done_cnt - d0), 128'(0));
        do_refill(8'd10, 32'h5A000000);
        do_read(8'd10, line);
        chk("clean_line", line, {32'h5A000003, 32'h5A000002, 32'h5A000001, 32'h5A000000});

        // Same-cycle read and store at index 7
        for (int b = 0; b < 4; b++) do_store(8'd7, 4'(b * 4), 4'hF, 32'h70000000 + 32'(b));
        @(negedge clk);
        rd_req_i = 1'b1; rd_index_i = 8'd7;
        st_wen_i = 4'b0011; st_index_i = 8'd7; st_offset_i = 4'h4; st_data_i = 32'h0000BEEF;
        #1;
        chk("haz_rd_gnt", 128'(rd_gnt_o), 128'(1));
        chk("haz_st_gnt", 128'(st_gnt_o), 128'(1));
        @(negedge clk);
        rd_req_i = 1'b0; st_wen_i = '0;
`ifdef DATA_ARRAY_BYPASS_EN
        exp_line = {32'h70000003, 32'h70000002, 32'h7000BEEF, 32'h70000000};
`else
        exp_line = {32'h70000003, 32'h70000002, 32'h70000001, 32'h70000000};
`endif
        chk("haz_line", rd_data_o, exp_line);
        do_read(8'd7, line);
        chk("haz_after", line, {32'h70000003, 32'h70000002, 32'h7000BEEF, 32'h70000000});

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/data_array.md
# data_array

Parametrised cache-line data array for the L1 caches: `BANK_NUM` banks of `BANK_DW` bits, indexed by cache set. Serves registered whole-line reads and byte-masked single-bank stores, and adds a refill engine that absorbs a line from the memory side one beat per bank under a valid/ready handshake. It sits between the cache controller (hit/store path) and the bus interface unit (refill path).

## Interface
- `BANK_NUM`, 4: banks per line; power of two, ≥2.
- `BANK_DW`, 32: bank width in bits; multiple of 8.
- `INDEX_AW`, 8: set-index width; depth per bank = 2^INDEX_AW.
- `OFFSET_AW`, derived = log2(BANK_NUM*BANK_DW/8): byte offset width within a line.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rd_req_i` in 1: line read request.
- `rd_index_i` in INDEX_AW: read set.
- `rd_gnt_o` out 1: read accepted this cycle.
- `rd_valid_o` out 1: `rd_data_o` holds the granted read's data.
- `rd_data_o` out BANK_NUM*BANK_DW: line; bank i at bits [(i+1)*BANK_DW-1 : i*BANK_DW].
- `st_wen_i` in BANK_DW/8: byte strobes; a store is requested when any bit is set.
- `st_index_i` in INDEX_AW: store set.
- `st_offset_i` in OFFSET_AW: byte offset; upper log2(BANK_NUM) bits select the bank.
- `st_data_i` in BANK_DW: store data.
- `st_gnt_o` out 1: store accepted this cycle.
- `refill_start_i` in 1: begin refill of a line.
- `refill_index_i` in INDEX_AW: refill set; sampled with the start.
- `refill_valid_i` in 1: refill beat valid.
- `refill_data_i` in BANK_DW: beat data, bank 0 first.
- `refill_ready_o` out 1: beat accepted when high with `refill_valid_i`.
- `refill_done_o` out 1: one-cycle pulse after the last beat is written.
- `busy_o` out 1: FSM not in IDLE.

## Operation
- FSM states: IDLE, REFILL, DONE.
  - IDLE → REFILL on `refill_start_i`; latches the index and clears beat counter `cnt`.
  - REFILL → DONE on the handshake with `cnt == BANK_NUM-1`.
  - DONE → IDLE unconditionally.
- REFILL: `refill_ready_o` = 1. Each valid&ready beat writes bank[`cnt`] at the latched index with all byte strobes set, then `cnt` increments. `refill_valid_i` low stalls without timeout.
- `refill_start_i` outside IDLE and `refill_valid_i` outside REFILL are ignored.
- `rd_gnt_o` = `rd_req_i` & IDLE; `st_gnt_o` = (|`st_wen_i`) & IDLE. CPU traffic is fully blocked in REFILL and DONE.
- In IDLE, a cycle carrying `refill_start_i` still grants that cycle's read and store.
- Store: writes only the bytes of bank `st_offset_i[OFFSET_AW-1 : log2(BANK_DW/8)]` selected by `st_wen_i`. Low offset bits are ignored; alignment is the caller's responsibility.
- Read and store granted in the same cycle at the same index: the read returns the pre-store line, unless the bypass described under Configuration is compiled in.
- Storage arrays are never reset; contents after reset are undefined.

## Timing
- Read latency 1: grant in cycle N → `rd_valid_o` = 1 and data in N+1. `rd_data_o` holds its value until the next granted read.
- Store and refill writes are visible to reads granted from the next cycle on.
- A refill of B beats with no stalls: start in N, beats in N+1..N+B, `refill_done_o` in N+B+1, IDLE and grants resume in N+B+2.
- Reset values: `rd_valid_o` 0, `rd_data_o` 0, `refill_ready_o` 0, `refill_done_o` 0, `busy_o` 0, FSM IDLE, `cnt` 0.
- `rd_gnt_o` and `st_gnt_o` are combinational from the inputs and state. All other outputs are registered or state-decoded.
- Reset mid-refill: return to IDLE immediately with no `refill_done_o`. The partially written line remains; the controller must invalidate its tag.

## Configuration
- `DATA_ARRAY_BYPASS_EN` defined: a read granted in the same cycle and at the same index as a granted store returns the line with the stored bytes merged in.
- Undefined: the same case returns the old line, and the controller must avoid the hazard.

## Structure
- Shared defines file: `CACHE_BANK_NUM`, `CACHE_INDEX_AW`, `CACHE_OFFSET_AW` and `DATA_WIDTH` as top-level parameter defaults, plus the FSM state encodings.
- One sub-module, `data_bank`: a parametrised single bank with byte write-enable, synchronous write and registered read (read register reset to 0), instantiated BANK_NUM times in a generate loop.

## Test plan
- Store 0xDEADBEEF, strobe 4'b1111, index 5, offset 0x8; then read index 5 → bank 2 = 0xDEADBEEF, `rd_valid_o` 1 exactly one cycle after the grant.
- Strobe 4'b0010, data 0x0000AB00, over that word → bank 2 = 0xDEADABEF.
- Refill index 3 with beats 0x11111111..0x44444444, `refill_valid_i` dropped for 2 cycles mid-burst → `refill_done_o` pulses once; read of index 3 = {0x44444444, 0x33333333, 0x22222222, 0x11111111}.
- Read and store requests during REFILL → both grants 0, no array change; a second `refill_start_i` is ignored.
- `rst_n` low after 2 beats → FSM IDLE, `refill_ready_o` 0, no `refill_done_o`; the next start refills cleanly.
- Same-cycle read and store to index 7 → old line without `DATA_ARRAY_BYPASS_EN`, merged line with it.
